sd_card_cmd_responder: RTL and testbench



---
 rtl/sd_card_pkg.sv | 19 +
 rtl/sd_card_crc7.sv | 34 +++
 rtl/sd_card_cmd_responder.sv | 245 ++++++++++++++++++++++++
 tb/tb_sd_card_cmd_responder.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_card_pkg.sv
// rtl/sd_card_pkg.sv - shared types and constants for the SD card CMD responder
package sd_card_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RX,
    ST_WAIT_RESP,
    ST_GAP,
    ST_TX,
    ST_TAIL
  } state_e;

  localparam logic [6:0] CRC7_POLY      = 7'h09;
  localparam int         CMD_FRAME_LEN  = 48;
  localparam int         RESP_LONG_LEN  = 136;
  localparam logic [5:0] R2_HEADER      = 6'b111111;
  localparam logic [6:0] R3_CRC_FILL    = 7'h7F;

endpackage

// File: rtl/sd_card_crc7.sv
// rtl/sd_card_crc7.sv - serial MSB-first CRC7 (x^7+x^3+1) with clear and enable
module sd_card_crc7
  import sd_card_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [6:0] crc
);

  logic [6:0] crc_q;
  logic [6:0] crc_d;
  logic [6:0] base;

  // Clear takes effect before the bit is folded in, so clr+en starts a fresh CRC with din.
  always_comb begin
    base  = clr ? 7'h00 : crc_q;
    crc_d = base;
    if (en) begin
      crc_d = {base[5:0], 1'b0} ^ ((din ^ base[6]) ? CRC7_POLY : 7'h00);
    end
  end

  // CRC register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) crc_q <= 7'h00;
    else     crc_q <= crc_d;
  end

  assign crc = crc_q;

endmodule

// File: rtl/sd_card_cmd_responder.sv
// rtl/sd_card_cmd_responder.sv - card-side SD CMD engine; RX CRC check under SD_CARD_CMD_CRC_CHECK_EN
module sd_card_cmd_responder
  import sd_card_pkg::*;
#(
  parameter int NCR          = 2,
  parameter int RESP_TIMEOUT = 64
) (
  input  logic         sd_clk,
  input  logic         cmd_rst,
  input  logic         sd_cmd_to_card,
  output logic         sd_cmd_to_host,
  output logic         sd_cmd_oe,
  output logic         cmd_valid,
  output logic [5:0]   cmd_index,
  output logic [31:0]  cmd_arg,
  output logic         cmd_crc_err,
  input  logic         resp_valid,
  output logic         resp_ready,
  input  logic         resp_long,
  input  logic         resp_crc_en,
  input  logic [127:0] resp_data,
  output logic         busy
);

  localparam logic [6:0] NCR_M1     = 7'(NCR - 1);
  localparam logic [6:0] TIMEOUT_M1 = 7'(RESP_TIMEOUT - 1);
  localparam logic [5:0] RX_LAST    = 6'(CMD_FRAME_LEN - 1);
  localparam logic [7:0] TOP_SHORT  = 8'(CMD_FRAME_LEN - 1);
  localparam logic [7:0] TOP_LONG   = 8'(RESP_LONG_LEN - 1);
  localparam logic [7:0] CRC_TOP_L  = 8'(RESP_LONG_LEN - 9);

  state_e         state_q, state_d;
  logic [6:0]     cnt_q, cnt_d;
  logic [45:0]    rx_sh_q, rx_sh_d;
  logic [5:0]     rx_cnt_q, rx_cnt_d;
  logic [135:0]   tx_frame_q, tx_frame_d;
  logic [7:0]     tx_idx_q, tx_idx_d;
  logic           resp_long_q, resp_long_d;
  logic           resp_crc_en_q, resp_crc_en_d;
  logic           cmd_valid_q, cmd_valid_d;
  logic           cmd_crc_err_q, cmd_crc_err_d;
  logic [5:0]     cmd_index_q, cmd_index_d;
  logic [31:0]    cmd_arg_q, cmd_arg_d;
  logic           resp_ready_q, resp_ready_d;
  logic           oe_q, oe_d;
  logic           line_q, line_d;
  logic           busy_q, busy_d;

  logic [46:0]    rx_frame;
  logic           rx_crc_ok;
  logic           tx_emit, tx_bit, tx_crc_clr, tx_crc_en;
  logic [6:0]     tx_crc;
  logic [2:0]     crc_pos;
  logic           resp_lsb_unused;

  // Frame bits 46..0 with the bit on the line this cycle in position 0.
  assign rx_frame        = {rx_sh_q, sd_cmd_to_card};
  assign crc_pos         = tx_idx_q[2:0] - 3'd1;
  assign resp_lsb_unused = ^resp_data[7:0];

`ifdef SD_CARD_CMD_CRC_CHECK_EN
  logic       rx_crc_clr, rx_crc_en;
  logic [6:0] rx_crc;

  // RX CRC covers frame bits 47..8: the start bit seen in IDLE, then 39 more.
  always_comb begin
    rx_crc_clr = (state_q == ST_IDLE);
    rx_crc_en  = ((state_q == ST_IDLE) && !sd_cmd_to_card) ||
                 ((state_q == ST_RX) && (rx_cnt_q < 6'd40));
  end

  sd_card_crc7 u_rx_crc (
    .clk (sd_clk),
    .rst (cmd_rst),
    .clr (rx_crc_clr),
    .en  (rx_crc_en),
    .din (sd_cmd_to_card),
    .crc (rx_crc)
  );

  assign rx_crc_ok = (rx_frame[7:1] == rx_crc);
`else
  assign rx_crc_ok = 1'b1;
`endif

  sd_card_crc7 u_tx_crc (
    .clk (sd_clk),
    .rst (cmd_rst),
    .clr (tx_crc_clr),
    .en  (tx_crc_en),
    .din (tx_bit),
    .crc (tx_crc)
  );

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rx_sh_d       = rx_sh_q;
    rx_cnt_d      = rx_cnt_q;
    tx_frame_d    = tx_frame_q;
    tx_idx_d      = tx_idx_q;
    resp_long_d   = resp_long_q;
    resp_crc_en_d = resp_crc_en_q;
    cmd_index_d   = cmd_index_q;
    cmd_arg_d     = cmd_arg_q;
    cmd_valid_d   = 1'b0;
    cmd_crc_err_d = 1'b0;
    tx_emit       = 1'b0;
    tx_bit        = 1'b1;
    tx_crc_clr    = 1'b0;
    tx_crc_en     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!sd_cmd_to_card) begin
          state_d  = ST_RX;
          rx_sh_d  = '0;
          rx_cnt_d = 6'd1;
        end
      end
      ST_RX: begin
        rx_sh_d  = rx_frame[45:0];
        rx_cnt_d = rx_cnt_q + 6'd1;
        if ((rx_cnt_q == 6'd1) && !sd_cmd_to_card) begin
          state_d = ST_IDLE;
        end else if (rx_cnt_q == RX_LAST) begin
          if (rx_frame[46] && rx_frame[0] && rx_crc_ok) begin
            cmd_valid_d = 1'b1;
            cmd_index_d = rx_frame[45:40];
            cmd_arg_d   = rx_frame[39:8];
            cnt_d       = 7'd0;
            state_d     = ST_WAIT_RESP;
          end else begin
            cmd_crc_err_d = 1'b1;
            state_d       = ST_IDLE;
          end
        end
      end
      ST_WAIT_RESP: begin
        cnt_d = (cnt_q == 7'h7F) ? cnt_q : cnt_q + 7'd1;
        if (resp_valid && resp_ready_q) begin
          resp_long_d   = resp_long;
          resp_crc_en_d = resp_crc_en;
          // CRC field is held as zero here; it is substituted while shifting out.
          if (resp_long) begin
            tx_frame_d = {2'b00, R2_HEADER, resp_data[127:8], 7'h00, 1'b1};
            tx_idx_d   = TOP_LONG;
          end else begin
            tx_frame_d = {2'b00, resp_data[37:0], 7'h00, 1'b1, 88'h0};
            tx_idx_d   = TOP_SHORT;
          end
          state_d = ST_GAP;
        end else if (cnt_q == TIMEOUT_M1) begin
          state_d = ST_IDLE;
        end
      end
      ST_GAP: begin
        cnt_d = (cnt_q == 7'h7F) ? cnt_q : cnt_q + 7'd1;
        if (cnt_q >= NCR_M1) begin
          state_d    = ST_TX;
          tx_emit    = 1'b1;
          tx_crc_clr = 1'b1;
        end
      end
      ST_TX: begin
        // Index wraps to 8'hFF once the end bit has been emitted.
        if (tx_idx_q == 8'hFF) state_d = ST_TAIL;
        else                   tx_emit = 1'b1;
      end
      ST_TAIL: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (tx_emit) begin
      if ((tx_idx_q >= 8'd1) && (tx_idx_q <= 8'd7)) begin
        tx_bit = resp_crc_en_q ? tx_crc[crc_pos] : R3_CRC_FILL[crc_pos];
      end else begin
        tx_bit = tx_frame_q[135];
      end
      tx_crc_en  = (tx_idx_q >= 8'd8) && (tx_idx_q <= (resp_long_q ? CRC_TOP_L : TOP_SHORT));
      tx_frame_d = {tx_frame_q[134:0], 1'b0};
      tx_idx_d   = tx_idx_q - 8'd1;
    end

    oe_d         = ((state_d == ST_GAP) && (cnt_d >= NCR_M1)) ||
                   (state_d == ST_TX) || (state_d == ST_TAIL);
    line_d       = (state_d == ST_TX) ? tx_bit : 1'b1;
    resp_ready_d = (state_d == ST_WAIT_RESP);
    busy_d       = (state_d != ST_IDLE);
  end

  // All state and registered outputs; reset returns the line to idle-high immediately.
  always_ff @(posedge sd_clk or posedge cmd_rst) begin
    if (cmd_rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= 7'd0;
      rx_sh_q       <= '0;
      rx_cnt_q      <= 6'd0;
      tx_frame_q    <= '0;
      tx_idx_q      <= 8'd0;
      resp_long_q   <= 1'b0;
      resp_crc_en_q <= 1'b0;
      cmd_valid_q   <= 1'b0;
      cmd_crc_err_q <= 1'b0;
      cmd_index_q   <= 6'd0;
      cmd_arg_q     <= 32'd0;
      resp_ready_q  <= 1'b0;
      oe_q          <= 1'b0;
      line_q        <= 1'b1;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rx_sh_q       <= rx_sh_d;
      rx_cnt_q      <= rx_cnt_d;
      tx_frame_q    <= tx_frame_d;
      tx_idx_q      <= tx_idx_d;
      resp_long_q   <= resp_long_d;
      resp_crc_en_q <= resp_crc_en_d;
      cmd_valid_q   <= cmd_valid_d;
      cmd_crc_err_q <= cmd_crc_err_d;
      cmd_index_q   <= cmd_index_d;
      cmd_arg_q     <= cmd_arg_d;
      resp_ready_q  <= resp_ready_d;
      oe_q          <= oe_d;
      line_q        <= line_d;
      busy_q        <= busy_d;
    end
  end

  assign sd_cmd_to_host = line_q;
  assign sd_cmd_oe      = oe_q;
  assign cmd_valid      = cmd_valid_q;
  assign cmd_crc_err    = cmd_crc_err_q;
  assign cmd_index      = cmd_index_q;
  assign cmd_arg        = cmd_arg_q;
  assign resp_ready     = resp_ready_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_sd_card_cmd_responder.sv
// tb/tb_sd_card_cmd_responder.sv - self-checking bench for sd_card_cmd_responder
module tb_sd_card_cmd_responder;

  localparam int NCR = 2;
  localparam int TO  = 64;
`ifdef SD_CARD_CMD_CRC_CHECK_EN
  localparam bit CRC_CHK = 1'b1;
`else
  localparam bit CRC_CHK = 1'b0;
`endif

  logic         sd_clk = 1'b0;
  logic         cmd_rst = 1'b1;
  logic         sd_cmd_to_card = 1'b1;
  logic         sd_cmd_to_host, sd_cmd_oe, cmd_valid, cmd_crc_err, resp_ready, busy;
  logic [5:0]   cmd_index;
  logic [31:0]  cmd_arg;
  logic         resp_valid = 1'b0, resp_long = 1'b0, resp_crc_en = 1'b1;
  logic [127:0] resp_data = '0;

  always #5 sd_clk = ~sd_clk;

  sd_card_cmd_responder #(.NCR(NCR), .RESP_TIMEOUT(TO)) dut (
    .sd_clk(sd_clk), .cmd_rst(cmd_rst), .sd_cmd_to_card(sd_cmd_to_card),
    .sd_cmd_to_host(sd_cmd_to_host), .sd_cmd_oe(sd_cmd_oe), .cmd_valid(cmd_valid),
    .cmd_index(cmd_index), .cmd_arg(cmd_arg), .cmd_crc_err(cmd_crc_err),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_long(resp_long),
    .resp_crc_en(resp_crc_en), .resp_data(resp_data), .busy(busy)
  );

  int tests = 0, fails = 0, cyc = 0;
  int cv_n, cv_cyc, ce_n, ce_cyc, oe_len, oe_first, bad_line, busy_fall;
  logic [5:0]   cv_idx;
  logic [31:0]  cv_arg;
  logic         ce_busy, prev_busy = 1'b0;
  logic [139:0] cap;

  typedef struct {
    logic [47:0]  cmd;
    bit           respond, rl, ce;
    logic [127:0] d;
    bit           exp_v, exp_e;
    logic [5:0]   exp_idx;
    logic [31:0]  exp_arg;
    logic [135:0] exp_fr;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string name, input logic [139:0] got, input logic [139:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // One clock: sample outputs 1 time unit after the edge and log events.
  task automatic step();
    @(posedge sd_clk);
    #1;
    cyc++;
    if (cmd_valid) begin cv_n++; cv_cyc = cyc; cv_idx = cmd_index; cv_arg = cmd_arg; end
    if (cmd_crc_err) begin ce_n++; ce_cyc = cyc; ce_busy = busy; end
    if (sd_cmd_oe) begin
      if (oe_len == 0) oe_first = cyc;
      cap = {cap[138:0], sd_cmd_to_host};
      oe_len++;
    end else if (!sd_cmd_to_host) bad_line++;
    if (prev_busy && !busy) busy_fall = cyc;
    prev_busy = busy;
  endtask

  // CRC7 by polynomial long division of msg*x^7 by x^7+x^3+1.
  function automatic logic [6:0] crc7(input logic [135:0] msg, input int n);
    logic [142:0] w;
    w = {msg, 7'b0};
    for (int i = n + 6; i >= 7; i--)
      if (w[i]) w[i -: 8] = w[i -: 8] ^ 8'h89;
    return w[6:0];
  endfunction

  function automatic logic [47:0] mk_cmd(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] m;
    m = {2'b01, idx, arg};
    return {m, crc7(136'(m), 40), 1'b1};
  endfunction

  // Expected oe window: preamble 1, the response frame, tail 1.
  task automatic model_resp(input bit rl, input bit ce, input logic [127:0] d,
                            output logic [139:0] exp_cap, output int len);
    logic [119:0] body;
    logic [39:0]  m;
    logic [6:0]   c;
    if (rl) begin
      body    = d[127:8];
      c       = ce ? crc7(136'(body), 120) : 7'h7F;
      exp_cap = {1'b1, 2'b00, 6'h3F, body, c, 1'b1, 1'b1};
      len     = 138;
    end else begin
      m       = {2'b00, d[37:0]};
      c       = ce ? crc7(136'(m), 40) : 7'h7F;
      exp_cap = 140'({1'b1, m, c, 1'b1, 1'b1});
      len     = 50;
    end
  endtask

  task automatic run_cmd(input string tag, input logic [47:0] f, input int nbits,
                         input bit respond, input bit rl, input bit ce, input logic [127:0] d,
                         input int dly, input bit exp_v, input bit exp_e,
                         input logic [5:0] exp_idx, input logic [31:0] exp_arg,
                         input logic [139:0] exp_cap, input int exp_len);
    int ee_cyc, k;
    bit given;
    cv_n = 0; ce_n = 0; oe_len = 0; cap = '0; bad_line = 0; busy_fall = -1; oe_first = -1;
    given = 1'b0;
    resp_long = rl; resp_crc_en = ce; resp_data = d;
    if (respond && dly == 0) begin resp_valid = 1'b1; given = 1'b1; end
    for (int i = 47; i > 47 - nbits; i--) begin
      sd_cmd_to_card = f[i];
      step();
    end
    sd_cmd_to_card = 1'b1;
    ee_cyc = cyc;
    k = 0;
    while (busy && k < 400) begin
      if (respond && !given && cv_n > 0 && (cyc - cv_cyc) >= dly) begin
        resp_valid = 1'b1; given = 1'b1;
      end
      if (oe_len > 0) resp_valid = 1'b0;
      step();
      k++;
    end
    resp_valid = 1'b0;
    chk({tag, " idle_at_end"}, 140'(busy), 140'(0));
    repeat (3) step();
    chk({tag, " valid_pulses"}, cv_n, 140'(exp_v));
    chk({tag, " err_pulses"}, ce_n, 140'(exp_e));
    if (exp_v) begin
      chk({tag, " index"}, 140'(cv_idx), 140'(exp_idx));
      chk({tag, " arg"}, 140'(cv_arg), 140'(exp_arg));
      chk({tag, " valid_cycle"}, cv_cyc, ee_cyc);
      if (!respond) chk({tag, " timeout_cycle"}, busy_fall, ee_cyc + TO);
    end
    if (exp_e) begin
      chk({tag, " err_cycle"}, ce_cyc, ee_cyc);
      chk({tag, " busy_at_err"}, 140'(ce_busy), 140'(0));
    end
    chk({tag, " oe_len"}, oe_len, exp_len);
    if (exp_len > 0) begin
      chk({tag, " resp_bits"}, cap, exp_cap);
      if (dly == 0) chk({tag, " preamble_cycle"}, oe_first, ee_cyc + NCR - 1);
    end
    chk({tag, " line_idle_high"}, bad_line, 0);
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    logic [139:0] ec;
    int el;
    ec = '0; el = 0;
    if (v.respond && v.exp_v) begin
      el = v.rl ? 138 : 50;
      ec = v.rl ? {1'b1, v.exp_fr, 1'b1} : 140'({1'b1, v.exp_fr[47:0], 1'b1});
    end
    run_cmd(tag, v.cmd, 48, v.respond, v.rl, v.ce, v.d, 0, v.exp_v, v.exp_e,
            v.exp_idx, v.exp_arg, ec, el);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0]  f;
    logic [127:0] d;
    logic [139:0] ec;
    int           el, kind, nb, wait_k;
    bit           rsp, rl, ce, tr, ok, ev, er;

    tbl[0] = '{48'h400000000095, 1'b0, 1'b0, 1'b1, 128'h0, 1'b1, 1'b0, 6'd0, 32'h0, 136'h0};
    tbl[1] = '{48'h48000001AA87, 1'b1, 1'b0, 1'b1, {90'h0, 6'd8, 32'h1AA},
               1'b1, 1'b0, 6'd8, 32'h1AA, 136'h08000001AA13};
    tbl[2] = '{48'h770000000465, 1'b0, 1'b0, 1'b1, 128'h0, !CRC_CHK, CRC_CHK,
               6'h37, 32'h4, 136'h0};
    tbl[3] = '{48'h770000000065, 1'b1, 1'b0, 1'b0, {90'h0, 6'h3F, 32'h00FF8000},
               1'b1, 1'b0, 6'h37, 32'h0, 136'h3F00FF8000FF};
    tbl[4] = '{mk_cmd(6'd2, 32'h0), 1'b1, 1'b1, 1'b1, 128'h0, 1'b1, 1'b0, 6'd2, 32'h0,
               {8'h3F, 120'h0, 7'h00, 1'b1}};
    tbl[5] = '{48'h400000000094, 1'b0, 1'b0, 1'b1, 128'h0, 1'b0, 1'b1, 6'd0, 32'h0, 136'h0};

    cv_n = 0; ce_n = 0; oe_len = 0; cap = '0; bad_line = 0; busy_fall = -1; oe_first = -1;
    step(); step();
    chk("reset line", 140'(sd_cmd_to_host), 140'(1));
    chk("reset oe", 140'(sd_cmd_oe), 140'(0));
    chk("reset busy", 140'(busy), 140'(0));
    chk("reset ready", 140'(resp_ready), 140'(0));
    chk("reset valid", 140'(cmd_valid), 140'(0));
    chk("reset err", 140'(cmd_crc_err), 140'(0));
    chk("reset index", 140'(cmd_index), 140'(0));
    chk("reset arg", 140'(cmd_arg), 140'(0));
    cmd_rst = 1'b0;
    repeat (3) step();

    for (int i = 0; i < 6; i++) run_vec($sformatf("vec%0d", i), tbl[i]);

    // Transmission bit 0: frame dropped silently.
    run_cmd("trans_abort", 48'h0, 2, 1'b0, 1'b0, 1'b1, 128'h0, 0, 1'b0, 1'b0,
            6'd0, 32'h0, 140'h0, 0);

    // Reset in the middle of a response.
    resp_long = 1'b0; resp_crc_en = 1'b1; resp_data = tbl[1].d; resp_valid = 1'b1;
    oe_len = 0; cap = '0;
    for (int i = 47; i >= 0; i--) begin
      sd_cmd_to_card = tbl[1].cmd[i];
      step();
    end
    sd_cmd_to_card = 1'b1;
    wait_k = 0;
    while (oe_len < 22 && wait_k < 200) begin step(); wait_k++; end
    chk("rst_mid oe_reached", oe_len, 22);
    resp_valid = 1'b0;
    #2 cmd_rst = 1'b1;
    #1;
    chk("rst_mid oe_low", 140'(sd_cmd_oe), 140'(0));
    chk("rst_mid line_high", 140'(sd_cmd_to_host), 140'(1));
    chk("rst_mid busy_low", 140'(busy), 140'(0));
    repeat (3) step();
    cmd_rst = 1'b0;
    oe_len = 0;
    repeat (60) step();
    chk("rst_mid no_reemit", oe_len, 0);
    run_vec("after_rst", tbl[0]);

    // Randomised commands against the frame-rule model.
    for (int t = 0; t < 30; t++) begin
      f    = mk_cmd(6'($urandom), $urandom);
      kind = $urandom_range(0, 9);
      nb   = 48;
      if (kind == 0) f[$urandom_range(1, 45)] ^= 1'b1;
      else if (kind == 1) f[0] = 1'b0;
      else if (kind == 2) begin f[46] = 1'b0; nb = 2; end
      rsp = ($urandom_range(0, 3) != 0);
      rl  = $urandom_range(0, 1) != 0;
      ce  = $urandom_range(0, 1) != 0;
      d   = {$urandom, $urandom, $urandom, $urandom};
      tr  = f[46];
      ok  = f[0] && (!CRC_CHK || (f[7:1] == crc7(136'(f[47:8]), 40)));
      ev  = tr && ok;
      er  = tr && !ok;
      ec = '0; el = 0;
      if (ev && rsp) model_resp(rl, ce, d, ec, el);
      run_cmd($sformatf("rnd%0d", t), f, nb, rsp, rl, ce, d, $urandom_range(0, 15),
              ev, er, f[45:40], f[39:8], ec, el);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
